// File: rtl/log2_range_norm.sv
// rtl/log2_range_norm.sv - two-stage leading-one range reduction feeding the log2 core (optional LOG2_RANGE_NORM_ROUND_EN)
module log2_range_norm #(
    parameter int IN_W  = 24,
    parameter int EXP_W = $clog2(IN_W + 1)
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic             i_VALID,
    input  logic             i_DATA_VALID,
    input  logic [IN_W-1:0]  i_DATA,
    output logic             o_VALID,
    output logic             o_DATA_VALID,
    output logic [10:0]      o_MANT,
    output logic [EXP_W-1:0] o_EXP,
    output logic             o_ZERO
);

    logic [EXP_W-1:0] w_lead;
    logic             w_zero;

    logic             r_s1_valid;
    logic [IN_W-1:0]  r_s1_data;
    logic [EXP_W-1:0] r_s1_e;
    logic             r_s1_zero;

    logic [10:0]      w_shr;
    logic [10:0]      w_shl;
    logic [10:0]      w_mant_t;
    logic [10:0]      w_mant;
    logic [EXP_W-1:0] w_exp;

    logic             r_valid;
    logic [10:0]      r_mant;
    logic [EXP_W-1:0] r_exp;
    logic             r_zero;

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        w_lead = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (i_DATA[i]) w_lead = EXP_W'(i);
        end
        w_zero = (i_DATA == '0);
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_e     <= '0;
            r_s1_zero  <= 1'b0;
        end else if (i_VALID) begin
            r_s1_valid <= i_DATA_VALID;
            if (i_DATA_VALID) begin
                r_s1_data <= i_DATA;
                r_s1_e    <= w_lead;
                r_s1_zero <= w_zero;
            end
        end
    end

    // Each shift is only selected on the side of e=10 where its amount is non-negative.
    assign w_shr    = 11'(r_s1_data >> (r_s1_e - EXP_W'(10)));
    assign w_shl    = 11'(r_s1_data << (EXP_W'(10) - r_s1_e));
    assign w_mant_t = (r_s1_e >= EXP_W'(10)) ? w_shr : w_shl;

`ifdef LOG2_RANGE_NORM_ROUND_EN
    logic        w_rbit;
    logic [11:0] w_sum;
    assign w_rbit = (r_s1_e > EXP_W'(10)) && 1'(r_s1_data >> (r_s1_e - EXP_W'(11)));
    assign w_sum  = {1'b0, w_mant_t} + {11'd0, w_rbit};

    always_comb begin
        w_mant = w_sum[10:0];
        w_exp  = r_s1_e;
        if (r_s1_zero) begin
            w_mant = 11'h400;
            w_exp  = '0;
        end else if (w_sum[11]) begin
            w_mant = 11'h400;
            w_exp  = r_s1_e + EXP_W'(1);
        end
    end
`else
    always_comb begin
        w_mant = w_mant_t;
        w_exp  = r_s1_e;
        if (r_s1_zero) begin
            w_mant = 11'h400;
            w_exp  = '0;
        end
    end
`endif

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_valid <= 1'b0;
            r_mant  <= '0;
            r_exp   <= '0;
            r_zero  <= 1'b0;
        end else if (i_VALID) begin
            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_mant <= w_mant;
                r_exp  <= w_exp;
                r_zero <= r_s1_zero;
            end
        end
    end

    assign o_VALID      = i_VALID;
    assign o_DATA_VALID = r_valid;
    assign o_MANT       = r_mant;
    assign o_EXP        = r_exp;
    assign o_ZERO       = r_zero;

endmodule

// File: tb/tb_log2_range_norm.sv
// tb/tb_log2_range_norm.sv - directed self-checking bench for log2_range_norm (honours LOG2_RANGE_NORM_ROUND_EN)
module tb_log2_range_norm;

    localparam int IN_W  = 24;
    localparam int EXP_W = $clog2(IN_W + 1);

    logic             i_CLK = 1'b0;
    logic             i_RSTn = 1'b0;
    logic             i_VALID = 1'b0;
    logic             i_DATA_VALID = 1'b0;
    logic [IN_W-1:0]  i_DATA = '0;
    logic             o_VALID;
    logic             o_DATA_VALID;
    logic [10:0]      o_MANT;
    logic [EXP_W-1:0] o_EXP;
    logic             o_ZERO;

    int n_checks = 0;
    int n_fail   = 0;

    log2_range_norm #(.IN_W(IN_W)) dut (
        .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_VALID(i_VALID), .i_DATA_VALID(i_DATA_VALID),
        .i_DATA(i_DATA), .o_VALID(o_VALID), .o_DATA_VALID(o_DATA_VALID),
        .o_MANT(o_MANT), .o_EXP(o_EXP), .o_ZERO(o_ZERO)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic dv, input logic [10:0] mant,
                           input logic [EXP_W-1:0] exp, input logic zero);
        check({tag, ".dv"},   32'(o_DATA_VALID), 32'(dv));
        check({tag, ".mant"}, 32'(o_MANT),       32'(mant));
        check({tag, ".exp"},  32'(o_EXP),        32'(exp));
        check({tag, ".zero"}, 32'(o_ZERO),       32'(zero));
    endtask

    // One sample through the pipe: not visible after the first edge, visible after the second.
    task automatic single(input string tag, input logic [IN_W-1:0] x, input logic [10:0] mant,
                          input logic [EXP_W-1:0] exp, input logic zero);
        i_DATA = x; i_DATA_VALID = 1'b1;
        step();
        i_DATA_VALID = 1'b0;
        check({tag, ".lat1"}, 32'(o_DATA_VALID), 32'd0);
        step();
        chk_out(tag, 1'b1, mant, exp, zero);
        step();
        check({tag, ".pulse"}, 32'(o_DATA_VALID), 32'd0);
    endtask

    initial begin
        i_VALID = 1'b1;
        step(); step();
        chk_out("reset", 1'b0, 11'h000, '0, 1'b0);
        check("ovalid_hi", 32'(o_VALID), 32'd1);
        i_RSTn = 1'b1;
        step();
        chk_out("post_rel", 1'b0, 11'h000, '0, 1'b0);

        single("x1",     24'h000001, 11'h400, 5'd0,  1'b0);
        single("x3",     24'h000003, 11'h600, 5'd1,  1'b0);
        single("xA00",   24'h000A00, 11'h500, 5'd11, 1'b0);
        single("x3FF",   24'h0003FF, 11'h7FE, 5'd9,  1'b0);
        single("x400",   24'h000400, 11'h400, 5'd10, 1'b0);
        single("x800000",24'h800000, 11'h400, 5'd23, 1'b0);
`ifdef LOG2_RANGE_NORM_ROUND_EN
        single("xFFFFFF",24'hFFFFFF, 11'h400, 5'd24, 1'b0);
        single("xC01",   24'h000C01, 11'h601, 5'd11, 1'b0);
`else
        single("xFFFFFF",24'hFFFFFF, 11'h7FF, 5'd23, 1'b0);
        single("xC01",   24'h000C01, 11'h600, 5'd11, 1'b0);
`endif
        single("zero",   24'h000000, 11'h400, 5'd0,  1'b1);

        // Stream 1,2,4,8 with a three-cycle clock-enable gap after the second sample.
        i_DATA = 24'd1; i_DATA_VALID = 1'b1;
        step();
        i_DATA = 24'd2;
        step();
        chk_out("s0", 1'b1, 11'h400, 5'd0, 1'b0);
        i_VALID = 1'b0; i_DATA = 24'h123456;
        check("ovalid_lo", 32'(o_VALID), 32'd0);
        for (int g = 0; g < 3; g++) begin
            step();
            chk_out($sformatf("gap%0d", g), 1'b1, 11'h400, 5'd0, 1'b0);
        end
        i_VALID = 1'b1; i_DATA = 24'd4;
        step();
        chk_out("s1", 1'b1, 11'h400, 5'd1, 1'b0);
        i_DATA = 24'd8;
        step();
        chk_out("s2", 1'b1, 11'h400, 5'd2, 1'b0);
        i_DATA_VALID = 1'b0;
        step();
        chk_out("s3", 1'b1, 11'h400, 5'd3, 1'b0);
        step();
        check("s_end", 32'(o_DATA_VALID), 32'd0);

        // Asynchronous reset with two samples in flight.
        i_DATA = 24'h10; i_DATA_VALID = 1'b1;
        step();
        i_DATA = 24'h20;
        step();
        chk_out("pre_rst", 1'b1, 11'h400, 5'd4, 1'b0);
        i_DATA_VALID = 1'b0;
        #2 i_RSTn = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 11'h000, '0, 1'b0);
        step();
        i_RSTn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out($sformatf("no_stale%0d", k), 1'b0, 11'h000, '0, 1'b0);
        end
        single("after_rst", 24'h000005, 11'h500, 5'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
